// File: rtl/dclk_rx.sv
// dclk_rx: single-wire flit link receiver. Deserialises one start-bit framed
// word (LSB first) into a 2-entry output buffer. It drives registered
// back-pressure to the transmitter and a sticky overrun flag.

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module dclk_rx #(
  parameter string port = "unknown"
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  serial_in,
  output logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0]    parallel_out,
  output logic                                  valid,
  input  logic                                  ack,
  output logic                                  channel_busy,
  output logic                                  overrun,
  output logic                                  rx_active
);

  localparam int W   = `HDR_SZ + `PL_SZ + `ADDR_SZ;
  localparam int BCW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] bitcnt_q;
  logic [W-1:0]   shreg_q;
  logic [W-1:0]   word_in;
  logic           push;
  logic           pop;
  logic [1:0]     count_q;
  logic [W-1:0]   mem0_q, mem1_q;
  logic           overrun_q;
  logic           busy_q;

  // The final data bit is still on the wire when the word is pushed.
  assign word_in = {serial_in, shreg_q[W-1:1]};
  assign pop     = ack & (count_q != 2'd0);

  // Frame state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: wait for a start bit, then count W data bits and push
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (serial_in) state_d = SHIFT;
      end
      SHIFT: begin
        if (bitcnt_q == LAST_BIT) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter and right-shifting deserialiser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else if (state_q == SHIFT) begin
      shreg_q  <= word_in;
      bitcnt_q <= push ? '0 : bitcnt_q + 1'b1;
    end else begin
      bitcnt_q <= '0;
    end
  end

  // Two-entry buffer; a push into a full buffer without a pop is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= 2'd0;
      mem0_q    <= '0;
      mem1_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push && pop) begin
        if (count_q == 2'd1) begin
          mem0_q <= word_in;
        end else begin
          mem0_q <= mem1_q;
          mem1_q <= word_in;
        end
      end else if (push) begin
        case (count_q)
          2'd0: begin
            mem0_q  <= word_in;
            count_q <= 2'd1;
          end
          2'd1: begin
            mem1_q  <= word_in;
            count_q <= 2'd2;
          end
          default: overrun_q <= 1'b1;
        endcase
      end else if (pop) begin
        mem0_q  <= mem1_q;
        count_q <= count_q - 2'd1;
      end
    end
  end

  // Registered back-pressure; overrun holds the link blocked until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= 1'b0;
    else        busy_q <= (count_q != 2'd0) | overrun_q;
  end

  assign parallel_out = mem0_q;
  assign valid        = (count_q != 2'd0);
  assign channel_busy = busy_q;
  assign overrun      = overrun_q;
  assign rx_active    = (state_q == SHIFT);

endmodule

// File: tb/tb_dclk_rx.sv
// Bench for dclk_rx: directed frames plus a randomized run, checked
// every cycle against a queue-based model of the receive buffer.

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module tb_dclk_rx;

  localparam int W = `HDR_SZ + `PL_SZ + `ADDR_SZ;

  logic         clk;
  logic         reset;
  logic         serial_in;
  logic [W-1:0] parallel_out;
  logic         valid;
  logic         ack;
  logic         channel_busy;
  logic         overrun;
  logic         rx_active;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [W-1:0] q[$];
  bit           ovr_e;
  bit           busy_e;
  bit           act_e;

  dclk_rx #(.port("tb_link")) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .parallel_out(parallel_out),
    .valid       (valid),
    .ack         (ack),
    .channel_busy(channel_busy),
    .overrun     (overrun),
    .rx_active   (rx_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", {31'd0, valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) chk("data", {{(32-W){1'b0}}, parallel_out}, {{(32-W){1'b0}}, q[0]});
    chk("busy", {31'd0, channel_busy}, {31'd0, busy_e});
    chk("overrun", {31'd0, overrun}, {31'd0, ovr_e});
    chk("rx_active", {31'd0, rx_active}, {31'd0, act_e});
  endtask

  task automatic model_reset();
    q.delete();
    ovr_e  = 1'b0;
    busy_e = 1'b0;
    act_e  = 1'b0;
  endtask

  // One clock: drive at the falling edge, update model at the rising edge,
  // compare at the next falling edge. psh marks the edge that completes w.
  task automatic cyc(input logic sin, input logic a, input bit psh,
                     input logic [W-1:0] w, input bit act_after);
    bit p;
    serial_in = sin;
    ack       = a;
    @(posedge clk);
    p      = a && (q.size() != 0);
    busy_e = (q.size() != 0) || ovr_e;
    if (p) void'(q.pop_front());
    if (psh) begin
      if (q.size() < 2) q.push_back(w);
      else              ovr_e = 1'b1;
    end
    act_e = act_after;
    @(negedge clk);
    check_all();
  endtask

  function automatic logic ackv(input bit rnd);
    return rnd ? ($urandom_range(0, 3) != 0) : 1'b0;
  endfunction

  task automatic send_frame(input logic [W-1:0] w, input bit rnd, input logic ack_last);
    cyc(1'b1, ackv(rnd), 1'b0, '0, 1'b1);
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) cyc(w[i], rnd ? ackv(1'b1) : ack_last, 1'b1, w, 1'b0);
      else            cyc(w[i], ackv(rnd), 1'b0, '0, 1'b1);
    end
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) cyc(1'b0, ackv(rnd), 1'b0, '0, 1'b0);
  endtask

  task automatic pop_one();
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, {{(32-W){1'b0}}, parallel_out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, channel_busy}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_rx_active"}, {31'd0, rx_active}, 32'd0);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    serial_in = 1'b0;
    ack       = 1'b0;
    #1;
    check_zero("reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] w;
    reset     = 1'b1;
    serial_in = 1'b0;
    ack       = 1'b0;
    model_reset();
    #1;
    do_reset();
    idle(2, 1'b0);

    // 1: single frame, no ack, then drain
    send_frame(16'hA5C3, 1'b0, 1'b0);
    idle(2, 1'b0);
    pop_one();
    idle(2, 1'b0);

    // 2: two frames with one idle cycle, pop both
    send_frame(16'h0001, 1'b0, 1'b0);
    idle(1, 1'b0);
    send_frame(16'h8000, 1'b0, 1'b0);
    idle(2, 1'b0);
    pop_one();
    pop_one();
    idle(2, 1'b0);

    // 3: third frame overruns a full buffer
    send_frame(16'h0001, 1'b0, 1'b0);
    idle(1, 1'b0);
    send_frame(16'h8000, 1'b0, 1'b0);
    idle(1, 1'b0);
    w = W'($urandom);
    send_frame(w, 1'b0, 1'b0);
    idle(2, 1'b0);
    pop_one();
    pop_one();
    idle(3, 1'b0);
    do_reset();
    idle(1, 1'b0);

    // 4: pop on the push edge of a third frame into a full buffer
    w = W'($urandom);
    send_frame(w, 1'b0, 1'b0);
    idle(1, 1'b0);
    w = W'($urandom);
    send_frame(w, 1'b0, 1'b0);
    idle(1, 1'b0);
    send_frame(16'h1234, 1'b0, 1'b1);
    idle(1, 1'b0);
    pop_one();
    pop_one();
    idle(2, 1'b0);

    // 5: reset at bit 7 of a frame, then a clean 0xFFFF
    send_frame(16'h5A5A, 1'b0, 1'b0);
    idle(1, 1'b0);
    w = W'($urandom);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(w[i], 1'b0, 1'b0, '0, 1'b1);
    do_reset();
    idle(2, 1'b0);
    send_frame(16'hFFFF, 1'b0, 1'b0);
    idle(1, 1'b0);
    pop_one();
    idle(2, 1'b0);

    // 6: all-zero frame followed by all-one frame
    send_frame(16'h0000, 1'b0, 1'b0);
    idle(1, 1'b0);
    send_frame(16'hFFFF, 1'b0, 1'b0);
    idle(1, 1'b0);
    pop_one();
    pop_one();
    idle(2, 1'b0);

    // 7: random words, random gaps, random ack
    for (int k = 0; k < 60; k++) begin
      w = W'($urandom);
      send_frame(w, 1'b1, 1'b0);
      idle($urandom_range(1, 3), 1'b1);
    end
    for (int k = 0; k < 4; k++) pop_one();
    idle(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
